// File: rtl/adc_capture.sv
// ADC capture block: registered 8-bit sample input, level trigger,
// decimation, sample FIFO and a four-register CPU port.
//
// Ports:
//   clk      system clock, adc_data sampled on its rising edge
//   reset    asynchronous active-low reset
//   adc_data 8-bit unsigned ADC sample, valid every clk
//   cs/we    one-cycle register access strobe, 1 = write
//   addr     register index (0 CTRL, 1 STATUS, 2 DATA, 3 LEVEL/COUNT)
//   din      CPU write data
//   dout     registered CPU read data, held until the next read
//   irq      level interrupt, DONE & IRQ_EN
module adc_capture #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] adc_data,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [7:0]    adc_q;
    logic [7:0]    prev_q;
    logic [1:0]    state;
    logic          trig_en;
    logic          irq_en;
    logic [3:0]    dec;
    logic [7:0]    level;
    logic          ovf;
    logic          done;
    logic [3:0]    dec_cnt;
    logic [CW-1:0] samp_cnt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic wr_acc;
    logic rd_acc;
    logic arm_wr;
    logic ctrl_wr;
    logic stat_wr;
    logic trig_hit;
    logic in_cap;
    logic take;
    logic last;
    logic empty;
    logic full;
    logic push;
    logic pop;

    always_comb begin
        wr_acc   = cs & we;
        rd_acc   = cs & ~we;
        ctrl_wr  = wr_acc && (addr == 2'd0);
        stat_wr  = wr_acc && (addr == 2'd1);
        arm_wr   = ctrl_wr && din[0];
        trig_hit = (state == S_ARMED) &&
                   (prev_q < level) && (adc_q >= level);
        // The trigger cycle itself is the first capture cycle, so
        // it takes the first sample. An ARM write overrides all.
        in_cap   = !arm_wr &&
                   ((state == S_CAPTURE) || trig_hit);
        take     = in_cap && (dec_cnt == 4'd0);
        last     = (samp_cnt == CW'(DEPTH - 1));
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        pop      = rd_acc && (addr == 2'd2) && !empty;
        // A pop in the same cycle frees the slot being written.
        push     = take && (!full || pop);
    end

    assign irq = done & irq_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adc_q  <= 8'h00;
            prev_q <= 8'h00;
        end else begin
            adc_q  <= adc_data;
            prev_q <= adc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_en <= 1'b0;
            irq_en  <= 1'b0;
            dec     <= 4'd0;
            level   <= 8'h80;
        end else begin
            if (ctrl_wr) begin
                dec     <= din[7:4];
                irq_en  <= din[2];
                trig_en <= din[1];
            end
            if (wr_acc && (addr == 2'd3))
                level <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            dec_cnt  <= 4'd0;
            samp_cnt <= '0;
        end else if (arm_wr) begin
            state    <= din[1] ? S_ARMED : S_CAPTURE;
            dec_cnt  <= 4'd0;
            samp_cnt <= '0;
        end else if (in_cap) begin
            // >= keeps the counter bounded if DEC shrinks mid-run.
            dec_cnt <= (dec_cnt >= dec) ? 4'd0 : dec_cnt + 4'd1;
            state   <= (take && last) ? S_IDLE : S_CAPTURE;
            if (take)
                samp_cnt <= samp_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (arm_wr)
                done <= 1'b0;
            else if (take && last)
                done <= 1'b1;
            else if (stat_wr && din[3])
                done <= 1'b0;

            if (take && full && !pop)
                ovf <= 1'b1;
            else if (stat_wr && din[2])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= adc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= 8'h00;
        end else if (rd_acc) begin
            unique case (addr)
                2'd0: dout <= {dec, 1'b0, irq_en, trig_en, 1'b0};
                2'd1: dout <= {2'b00, state, done, ovf, full, empty};
                2'd2: dout <= pop ? mem[rd_ptr] : 8'h00;
                2'd3: dout <= 8'(count);
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Testbench for adc_capture: random/ramp ADC data against an
// event-level model of triggers, sample times and FIFO contents.
module tb_adc_capture;

    localparam int DEPTH = 16;
    localparam int HN    = 16384;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] adc_data = 8'h00;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq;

    adc_capture #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .adc_data (adc_data),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int pcount = 0;
    int last_w = 0;
    bit rnd    = 1'b0;

    logic [7:0] hist [HN];

    always @(posedge clk) begin
        if (pcount < HN)
            hist[pcount] <= adc_data;
        pcount <= pcount + 1;
    end

    always @(negedge clk)
        adc_data <= rnd ? 8'($urandom) : adc_data + 8'd1;

    logic [7:0] mq [$];
    bit         m_arm, m_cap, m_done, m_ovf;
    bit         m_trig, m_irqen;
    logic [3:0] m_dec;
    logic [7:0] m_level;
    int         m_scan, m_nxt, m_step, m_rem, m_done_p;

    function automatic void m_reset();
        mq.delete();
        m_arm = 0; m_cap = 0; m_done = 0; m_ovf = 0;
        m_trig = 0; m_irqen = 0; m_dec = 4'd0;
        m_level = 8'h80;
        m_done_p = -1;
    endfunction

    // Apply every trigger and sample event up to posedge upto.
    // adc_q after posedge p equals hist[p].
    function automatic void adv(input int upto);
        while (m_arm && m_scan + 1 <= upto) begin
            if (hist[m_scan-1] < m_level && hist[m_scan] >= m_level) begin
                m_arm = 0;
                m_cap = 1;
                m_nxt = m_scan + 1;
            end
            m_scan++;
        end
        while (m_cap && m_nxt <= upto) begin
            if (mq.size() < DEPTH)
                mq.push_back(hist[m_nxt-1]);
            else
                m_ovf = 1;
            m_rem--;
            if (m_rem == 0) begin
                m_cap = 0;
                m_done = 1;
                m_done_p = m_nxt;
            end
            m_nxt += m_step;
        end
    endfunction

    function automatic void m_arm_at(input int w, input logic [7:0] d);
        adv(w - 1);
        m_trig = d[1]; m_irqen = d[2]; m_dec = d[7:4];
        m_done = 0;
        m_step = int'(d[7:4]) + 1;
        m_rem = DEPTH;
        if (d[1]) begin
            m_arm = 1; m_cap = 0; m_scan = w;
        end else begin
            m_arm = 0; m_cap = 1; m_nxt = w + 1;
        end
    endfunction

    function automatic logic [7:0] m_status();
        logic [1:0] code;
        code = m_arm ? 2'd1 : (m_cap ? 2'd2 : 2'd0);
        return {2'b00, code, m_done, m_ovf,
                mq.size() == DEPTH, mq.size() == 0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        adv(pcount - 1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        int w;
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        w = pcount - 1;
        last_w = w;
        case (a)
            2'd0: begin
                if (d[0]) m_arm_at(w, d);
                else begin
                    adv(w);
                    m_trig = d[1]; m_irqen = d[2]; m_dec = d[7:4];
                end
            end
            2'd1: begin
                adv(w - 1);
                if (d[3]) m_done = 0;
                if (d[2]) m_ovf = 0;
                adv(w);
            end
            2'd3: begin
                adv(w);
                m_level = d;
            end
            default: adv(w);
        endcase
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      output logic [7:0] d);
        int r;
        logic [7:0] e;
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        r = pcount - 1;
        d = dout;
        adv(r - 1);
        case (a)
            2'd0: e = {m_dec, 1'b0, m_irqen, m_trig, 1'b0};
            2'd1: e = m_status();
            2'd2: e = (mq.size() > 0) ? mq.pop_front() : 8'h00;
            default: e = 8'(mq.size());
        endcase
        adv(r);
        chk(tag, d, e);
    endtask

    task automatic wait_done(input int lim);
        int g = 0;
        while (!m_done && g < lim) begin
            tick();
            g++;
        end
        chk("wait_done", m_done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] first;
        int w;
        int hi;
        int n;

        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_irq", irq, 0);
        chk("rst_dout", dout, 8'h00);
        reset = 1'b1;
        repeat (3) tick();
        rd("rst_status", 2'd1, v);
        chk("rst_status_val", v, 8'h01);
        rd("rst_ctrl", 2'd0, v);
        rd("rst_count", 2'd3, v);

        // Untriggered ramp capture, DEC=0.
        wr(2'd0, 8'h01);
        wait_done(200);
        rd("t1_status", 2'd1, v);
        chk("t1_status_val", v, 8'h0A);
        first = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            rd("t1_data", 2'd2, v);
            if (i == 0) first = v;
            else chk("t1_ramp", v, 32'(8'(first + 8'(i))));
        end
        rd("t1_empty", 2'd1, v);
        chk("dout_hold_a", dout, v);
        repeat (3) tick();
        chk("dout_hold_b", dout, v);
        wr(2'd1, 8'h08);

        // Triggered capture at LEVEL=0x40 on a ramp.
        wr(2'd3, 8'h40);
        for (int g = 0; g < 600 && hist[pcount-1] != 8'h10; g++)
            tick();
        wr(2'd0, 8'h03);
        rd("t2_armed", 2'd1, v);
        chk("t2_state_armed", v[5:4], 2'd1);
        for (int g = 0; g < 600 && hist[pcount-1] != 8'h44; g++)
            tick();
        rd("t2_cap", 2'd1, v);
        chk("t2_state_cap", v[5:4], 2'd2);
        wait_done(200);
        rd("t2_first", 2'd2, v);
        chk("t2_first_val", v, 8'h40);
        for (int i = 1; i < DEPTH; i++)
            rd("t2_data", 2'd2, v);
        wr(2'd1, 8'h08);

        // Decimation DEC=3 with random data and IRQ_EN.
        rnd = 1'b1;
        wr(2'd0, 8'h35);
        w = last_w;
        hi = -1;
        for (int g = 0; g < 80; g++) begin
            tick();
            chk("t3_irq", irq, m_done & m_irqen);
            if (irq && hi < 0) hi = pcount - 1 - w;
        end
        chk("t3_done_lat", hi, 61);
        for (int i = 0; i < DEPTH; i++)
            rd("t3_data", 2'd2, v);
        wr(2'd1, 8'h08);
        tick();
        chk("t3_irq_clr", irq, 0);

        // Overflow on re-arm with a full FIFO.
        wr(2'd0, 8'h01);
        wait_done(200);
        wr(2'd0, 8'h01);
        wait_done(200);
        rd("t4_status", 2'd1, v);
        chk("t4_status_val", v, 8'h0E);
        rd("t4_count", 2'd3, v);
        chk("t4_count_val", v, 8'd16);
        wr(2'd1, 8'h0C);
        rd("t4_clr", 2'd1, v);
        chk("t4_clr_val", v, 8'h02);
        rd("t4_data0", 2'd2, v);

        // Pushes coinciding with pops, including one while full.
        wr(2'd0, 8'h71);
        w = last_w;
        while (pcount - 1 < w + 7) tick();
        for (int i = 0; i < 20; i++)
            rd("t5_pp_data", 2'd2, v);
        rd("t5_pp_status", 2'd1, v);
        chk("t5_no_ovf", v[2], 1'b0);
        wait_done(300);
        rd("t5_count", 2'd3, v);
        n = mq.size();
        for (int i = 0; i < n; i++)
            rd("t5_drain", 2'd2, v);
        rd("t5_empty_rd", 2'd2, v);
        chk("t5_empty_val", v, 8'h00);
        rd("t5_empty_cnt", 2'd3, v);
        chk("t5_empty_cnt_val", v, 8'd0);

        // Reset during capture after five pushes.
        wr(2'd1, 8'h08);
        rnd = 1'b0;
        wr(2'd0, 8'h05);
        w = last_w;
        while (pcount - 1 < w + 5) tick();
        rd("t6_count_pre", 2'd3, v);
        reset = 1'b0;
        m_reset();
        repeat (2) tick();
        chk("t6_irq_rst", irq, 0);
        chk("t6_dout_rst", dout, 8'h00);
        reset = 1'b1;
        repeat (3) tick();
        rd("t6_status", 2'd1, v);
        chk("t6_status_val", v, 8'h01);
        rd("t6_count", 2'd3, v);
        chk("t6_count_val", v, 8'd0);
        chk("t6_irq", irq, 0);
        wr(2'd0, 8'h03);
        wait_done(600);
        rd("t6_first", 2'd2, v);
        chk("t6_first_val", v, 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
